// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divider: FSM encodings, handshake levels, bus widths.
package div_unit_pkg;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic        RESET_ENABLE     = 1'b1;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam int          DOUBLE_REG_BUS_W = 64;
    localparam int          DIV_CNT_W        = 6;

    // Sign fix-ups latched at capture and applied on the last step.
    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } div_fix_t;

endpackage

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU; result {remainder, quotient} held for HI/LO write.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    logic [1:0]           r_state;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_divisor;
    div_fix_t             r_fix;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;

    logic             w_neg1, w_neg2;
    logic [WIDTH-1:0] w_mag1, w_mag2;
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_rem_next, w_quot_next;
    logic [WIDTH-1:0] w_q_fix, w_r_fix;
    logic             w_last;

    assign w_neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign w_neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign w_mag1 = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_mag2 = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_rem_next  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

    assign w_q_fix = r_fix.neg_q ? (~w_quot_next + 1'b1) : w_quot_next;
    assign w_r_fix = r_fix.neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_last  = (r_cnt == DIV_CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_fix     <= '0;
            r_result  <= '0;
            r_ready   <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && !annul_i) begin
                        r_cnt       <= '0;
                        r_rem       <= '0;
                        r_quot      <= w_mag1;
                        r_divisor   <= w_mag2;
                        r_fix.neg_q <= w_neg1 ^ w_neg2;
                        r_fix.neg_r <= w_neg1;
                        r_state     <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_READY;
                    r_state  <= DIV_END;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_state  <= DIV_FREE;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + 1'b1;
                        // The 32nd step's edge also commits the corrected result.
                        if (w_last) begin
                            r_result <= {w_r_fix, w_q_fix};
                            r_ready  <= DIV_RESULT_READY;
                            r_state  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_state  <= DIV_FREE;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul/reset corner sequences.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i, opdata2_i;
    logic           start_i, annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_res;
        int             exp_lat;   // edges counted from and including the capture edge
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Starts at the capture edge; scrambles operands right after capture.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            if (ready_o) break;
        end
    endtask

    task automatic run_op(input vec_t v, input string name);
        int n;
        start_op(v.sgn, v.a, v.b);
        wait_ready(n);
        check({name, " latency"}, 64'(n), 64'(v.exp_lat));
        check({name, " result"}, result_o, v.exp_res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " ready drop"}, {63'd0, ready_o}, 64'd0);
        check({name, " result clear"}, result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000000F_0FFFFFFF, 33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33};
        vecs[3]  = '{1'b0, 32'h0000_1234, 32'h0000_0000, 64'h0,                 2};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33};
        vecs[5]  = '{1'b0, 32'd100,       32'd3,         64'h00000001_00000021, 33};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 33};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFFFFFF_00000003, 33};
        vecs[8]  = '{1'b0, 32'd5,         32'd7,         64'h00000005_00000000, 33};
        vecs[9]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 64'h0,                 2};
        vecs[10] = '{1'b0, 32'hFFFF_FFFE, 32'd2,         64'h00000000_7FFFFFFF, 33};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset state", 64'(dut.r_state), 64'(DIV_FREE));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // start blocked by annul in FREE
        start_op(1'b0, 32'd100, 32'd3);
        annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("annul free state", 64'(dut.r_state), 64'(DIV_FREE));
        check("annul free ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;

        // annul after 10 steps of 100/3
        start_op(1'b0, 32'd100, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul step10 state", 64'(dut.r_state), 64'(DIV_FREE));
        check("annul step10 ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("annul step10 ready later", {63'd0, ready_o}, 64'd0);
        run_op(vecs[5], "after annul");

        // annul coinciding with the final step
        start_op(1'b0, 32'd100, 32'd3);
        repeat (32) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul last ready", {63'd0, ready_o}, 64'd0);
        check("annul last state", 64'(dut.r_state), 64'(DIV_FREE));
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;

        // annul in END is ignored
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_ready(n);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul end ready", {63'd0, ready_o}, 64'd1);
        check("annul end result", result_o, 64'hFFFFFFFF_FFFFFFFD);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        @(posedge clk);

        // reset mid-ON
        start_op(1'b0, 32'd100, 32'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst on ready", {63'd0, ready_o}, 64'd0);
        check("rst on result", result_o, 64'd0);
        check("rst on state", 64'(dut.r_state), 64'(DIV_FREE));
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;

        // reset in END with start still held
        start_op(1'b0, 32'd100, 32'd3);
        wait_ready(n);
        check("pre-rst end ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst end ready", {63'd0, ready_o}, 64'd0);
        check("rst end result", result_o, 64'd0);
        check("rst end state", 64'(dut.r_state), 64'(DIV_FREE));
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;

        run_op(vecs[0], "post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
